// File: rtl/video_timing_pattern_gen.sv
// rtl/video_timing_pattern_gen.sv - raster timing (vsync/hsync/de) plus 24-bit test-pattern source
`timescale 1ns/1ps
module video_timing_pattern_gen #(
  parameter int HRES = 320,
  parameter int VRES = 240,
  parameter int HSW  = 16,
  parameter int HBP  = 16,
  parameter int HFP  = 8,
  parameter int VSW  = 2,
  parameter int VBP  = 2,
  parameter int VFP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern,
  input  logic [23:0] i_color,
  output logic        o_vsync,
  output logic        o_hsync,
  output logic        o_de,
  output logic [23:0] o_data,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt
);

  localparam int HTOT = HSW + HBP + HRES + HFP;
  localparam int VTOT = VSW + VBP + VRES + VFP;

  localparam logic [15:0] H_SYNC  = 16'(HSW);
  localparam logic [15:0] H_PRE   = 16'(HSW + HBP - 1);
  localparam logic [15:0] H_ACT0  = 16'(HSW + HBP);
  localparam logic [15:0] H_ACT1  = 16'(HSW + HBP + HRES);
  localparam logic [15:0] H_LAST  = 16'(HTOT - 1);
  localparam logic [15:0] V_SYNC  = 16'(VSW);
  localparam logic [15:0] V_ACT0  = 16'(VSW + VBP);
  localparam logic [15:0] V_ACT1  = 16'(VSW + VBP + VRES);
  localparam logic [15:0] V_LAST  = 16'(VTOT - 1);
  localparam logic [15:0] BAR_END = 16'(HRES / 8 - 1);
  localparam logic [7:0]  H_ACT0B = 8'(HSW + HBP);
  localparam logic [7:0]  V_ACT0B = 8'(VSW + VBP);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t      state;
  state_t      stateNext;
  logic [15:0] hcnt;
  logic [15:0] vcnt;
  logic [1:0]  patSh;
  logic [23:0] colSh;
  logic [15:0] barPix;
  logic [2:0]  barIdx;
  logic [7:0]  x8;
  logic [7:0]  y8;
  logic [7:0]  gray;
  logic [23:0] barColor;
  logic [23:0] pix;
  logic        lineEnd;
  logic        frameEnd;
  logic        hAct;
  logic        vAct;
  logic        lastPix;

  assign lineEnd  = (hcnt == H_LAST);
  assign frameEnd = lineEnd && (vcnt == V_LAST);
  assign hAct     = (hcnt >= H_ACT0) && (hcnt < H_ACT1);
  assign vAct     = (vcnt >= V_ACT0) && (vcnt < V_ACT1);
  assign lastPix  = (hcnt == H_ACT1 - 16'd1) && (vcnt == V_ACT1 - 16'd1);
  // Only the low byte of x/y is ever needed, so subtract in 8 bits.
  assign x8   = hcnt[7:0] - H_ACT0B;
  assign y8   = vcnt[7:0] - V_ACT0B;
  assign gray = x8 + y8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Dropping enable in RUN always lets the current frame run to its end.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (i_enable) stateNext = RUN;
      RUN:  if (!i_enable) stateNext = frameEnd ? IDLE : STOP;
      STOP: if (frameEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (state == IDLE) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (lineEnd) begin
      hcnt <= '0;
      vcnt <= frameEnd ? 16'd0 : vcnt + 16'd1;
    end else begin
      hcnt <= hcnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      patSh <= '0;
      colSh <= '0;
    end else if (hcnt == 16'd0 && vcnt == 16'd0) begin
      patSh <= i_pattern;
      colSh <= i_color;
    end
  end

  // Bar position tracks hcnt so the registers describe the current pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      barPix <= '0;
      barIdx <= '0;
    end else if (state == IDLE || hcnt == H_PRE) begin
      barPix <= '0;
      barIdx <= '0;
    end else if (hAct) begin
      if (barPix == BAR_END) begin
        barPix <= '0;
        barIdx <= barIdx + 3'd1;
      end else begin
        barPix <= barPix + 16'd1;
      end
    end
  end

  always_comb begin
    barColor = 24'h000000;
    case (barIdx)
      3'd0: barColor = 24'hFFFFFF;
      3'd1: barColor = 24'hFFFF00;
      3'd2: barColor = 24'h00FFFF;
      3'd3: barColor = 24'h00FF00;
      3'd4: barColor = 24'hFF00FF;
      3'd5: barColor = 24'hFF0000;
      3'd6: barColor = 24'h0000FF;
      default: barColor = 24'h000000;
    endcase
  end

  always_comb begin
    pix = 24'h000000;
    case (patSh)
      2'd0: pix = barColor;
      2'd1: pix = {gray, gray, gray};
      2'd2: pix = colSh;
      default: pix = (x8[3] ^ y8[3] ^ o_frame_cnt[0]) ? 24'hFFFFFF : 24'h000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vsync      <= 1'b0;
      o_hsync      <= 1'b0;
      o_de         <= 1'b0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
    end else if (state == IDLE) begin
      o_vsync      <= 1'b0;
      o_hsync      <= 1'b0;
      o_de         <= 1'b0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_vsync      <= (vcnt < V_SYNC);
      o_hsync      <= (hcnt < H_SYNC);
      o_de         <= hAct && vAct;
      o_data       <= (hAct && vAct) ? pix : 24'h000000;
      o_frame_done <= lastPix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            o_frame_cnt <= '0;
    else if (o_frame_done) o_frame_cnt <= o_frame_cnt + 16'd1;
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// tb/tb_video_timing_pattern_gen.sv - scoreboard bench for video_timing_pattern_gen
`timescale 1ns/1ps
module tb_video_timing_pattern_gen;

  localparam int HRES = 64;
  localparam int VRES = 16;
  localparam int HSW  = 4;
  localparam int HBP  = 3;
  localparam int HFP  = 2;
  localparam int VSW  = 2;
  localparam int VBP  = 2;
  localparam int VFP  = 1;
  localparam int HTOT = HSW + HBP + HRES + HFP;
  localparam int VTOT = VSW + VBP + VRES + VFP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [1:0]  i_pattern = 2'd0;
  logic [23:0] i_color = 24'h0;
  logic        o_vsync;
  logic        o_hsync;
  logic        o_de;
  logic [23:0] o_data;
  logic        o_frame_done;
  logic [15:0] o_frame_cnt;

  video_timing_pattern_gen #(
    .HRES(HRES), .VRES(VRES), .HSW(HSW), .HBP(HBP), .HFP(HFP),
    .VSW(VSW), .VBP(VBP), .VFP(VFP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_pattern(i_pattern),
    .i_color(i_color), .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
    .o_data(o_data), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] expQ[$];
  logic [23:0] barTab [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int deTot = 0, hsRise = 0, vsClk = 0, doneTot = 0, busyClk = 0, runLen = 0;
  logic prevHs = 1'b0, prevDe = 1'b0;
  int expCnt = 0;

  task automatic check24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] expPix(input int pat, input logic [23:0] col,
                                         input int x, input int y, input int par);
    logic [7:0] g;
    case (pat)
      0: return barTab[x / (HRES / 8)];
      1: begin g = 8'((x + y) % 256); return {g, g, g}; end
      2: return col;
      default: return ((((x / 8) + (y / 8) + par) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic pushFrame(input int pat, input logic [23:0] col, input int par);
    for (int y = 0; y < VRES; y++)
      for (int x = 0; x < HRES; x++)
        expQ.push_back(expPix(pat, col, x, y, par));
  endtask

  task automatic monitor();
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevHs = 1'b0;
        prevDe = 1'b0;
        runLen = 0;
      end else begin
        if (o_de) begin
          deTot++;
          runLen++;
          checkInt("pixel_expected", (expQ.size() > 0) ? 1 : 0, 1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check24("pixel", o_data, e);
          end
        end else begin
          check24("blank_data", o_data, 24'h0);
          if (prevDe) checkInt("line_len", runLen, HRES);
          runLen = 0;
        end
        if (o_hsync && !prevHs) hsRise++;
        if (o_vsync) vsClk++;
        if (o_frame_done) doneTot++;
        if (o_vsync || o_hsync || o_de || o_frame_done) busyClk++;
        prevHs = o_hsync;
        prevDe = o_de;
      end
    end
  endtask

  task automatic waitFrameDone();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_frame_done && n < 3 * HTOT * VTOT);
    checkInt("frame_done_seen", int'(o_frame_done), 1);
    checkInt("cnt_before_inc", int'(o_frame_cnt), expCnt);
    expCnt++;
    @(negedge clk);
    checkInt("frame_cnt", int'(o_frame_cnt), expCnt);
  endtask

  task automatic waitIdle();
    int b0;
    repeat (HFP + VFP * HTOT + 4) @(negedge clk);
    b0 = busyClk;
    repeat (20) @(negedge clk);
    checkInt("idle_quiet", busyClk - b0, 0);
    checkInt("queue_drained", expQ.size(), 0);
  endtask

  task automatic runOne(input int pat, input logic [23:0] col);
    i_pattern = 2'(pat);
    i_color = col;
    pushFrame(pat, col, expCnt % 2);
    i_enable = 1'b1;
    repeat (3) @(negedge clk);
    i_enable = 1'b0;
    waitFrameDone();
    waitIdle();
  endtask

  initial begin
    int d0, h0, v0, f0, n;
    fork monitor(); join_none

    // reset and idle
    repeat (3) @(negedge clk);
    check24("rst_data", o_data, 24'h0);
    checkInt("rst_ctl", int'({o_vsync, o_hsync, o_de, o_frame_done}), 0);
    checkInt("rst_cnt", int'(o_frame_cnt), 0);
    rst_n = 1'b1;
    d0 = busyClk;
    repeat (200) @(negedge clk);
    checkInt("idle_200", busyClk - d0, 0);
    check24("idle_data", o_data, 24'h0);

    // one gray-ramp frame: start latency and frame timing totals
    i_pattern = 2'd1;
    pushFrame(1, 24'h0, 0);
    d0 = deTot; h0 = hsRise; v0 = vsClk; f0 = doneTot;
    i_enable = 1'b1;
    @(negedge clk);
    checkInt("start_hsync_early", int'(o_hsync), 0);
    @(negedge clk);
    checkInt("start_hsync", int'(o_hsync), 1);
    checkInt("start_vsync", int'(o_vsync), 1);
    i_enable = 1'b0;
    waitFrameDone();
    waitIdle();
    checkInt("de_total", deTot - d0, HRES * VRES);
    checkInt("hsync_pulses", hsRise - h0, VTOT);
    checkInt("vsync_clks", vsClk - v0, VSW * HTOT);
    checkInt("done_pulses", doneTot - f0, 1);

    // colour bars
    runOne(0, 24'h0);

    // checker over two back-to-back frames
    i_pattern = 2'd3;
    pushFrame(3, 24'h0, expCnt % 2);
    pushFrame(3, 24'h0, (expCnt + 1) % 2);
    v0 = vsClk; f0 = doneTot;
    i_enable = 1'b1;
    waitFrameDone();
    n = 0;
    while (!o_de && n < HTOT * VTOT) begin @(negedge clk); n++; end
    checkInt("second_frame_started", int'(o_de), 1);
    i_enable = 1'b0;
    waitFrameDone();
    waitIdle();
    checkInt("two_frames_vsync", vsClk - v0, 2 * VSW * HTOT);
    checkInt("two_frames_done", doneTot - f0, 2);

    // disable and pattern change mid-frame: bars finish, then solid colour
    i_pattern = 2'd0;
    i_color = 24'h123456;
    pushFrame(0, 24'h0, 0);
    i_enable = 1'b1;
    repeat ((VSW + VBP + 8) * HTOT) @(negedge clk);
    i_enable = 1'b0;
    i_pattern = 2'd2;
    i_color = 24'h3C5A96;
    waitFrameDone();
    waitIdle();
    runOne(2, 24'h3C5A96);

    // asynchronous reset in the middle of an active line
    i_pattern = 2'd1;
    pushFrame(1, 24'h0, 0);
    i_enable = 1'b1;
    n = 0;
    while (!o_de && n < HTOT * VTOT) begin @(negedge clk); n++; end
    checkInt("pre_reset_active", int'(o_de), 1);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check24("async_rst_data", o_data, 24'h0);
    checkInt("async_rst_ctl", int'({o_vsync, o_hsync, o_de, o_frame_done}), 0);
    checkInt("async_rst_cnt", int'(o_frame_cnt), 0);
    expQ.delete();
    i_enable = 1'b0;
    expCnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    runOne(3, 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
